// File: rtl/dfe_coeff_loader_pkg.sv
// Shared types and constants for the Phase-1 coefficient loader.
// Bank codes, loader FSM states and the per-bank required burst length.
package dfe_coeff_pkg;

  localparam int NUM_COEFF_DEPTH = 3;
  localparam int DEN_COEFF_DEPTH = 2;
  localparam int N_TAP_DEFAULT   = 72;

  typedef enum logic [2:0] {
    TGT_FRAC_DEC = 3'd0,
    TGT_NUM_2_4  = 3'd1,
    TGT_DEN_2_4  = 3'd2,
    TGT_NUM_2    = 3'd3,
    TGT_DEN_2    = 3'd4,
    TGT_NUM_1    = 3'd5,
    TGT_DEN_1    = 3'd6,
    TGT_ILLEGAL  = 3'd7
  } coeff_target_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    DRAIN  = 2'd3
  } loader_state_e;

  // Exact word count a burst must carry to commit; 0 marks the illegal code.
  // The decimator depth is an argument so a top with a non-default tap count
  // can still share this function.
  function automatic int target_depth(coeff_target_e t, int frac_depth = N_TAP_DEFAULT);
    case (t)
      TGT_FRAC_DEC:                      target_depth = frac_depth;
      TGT_NUM_2_4, TGT_NUM_2, TGT_NUM_1: target_depth = NUM_COEFF_DEPTH;
      TGT_DEN_2_4, TGT_DEN_2, TGT_DEN_1: target_depth = DEN_COEFF_DEPTH;
      default:                           target_depth = 0;
    endcase
  endfunction

endpackage

// File: rtl/dfe_coeff_loader_if.sv
// Ready/valid configuration stream between the bus bridge and the loader.
// master = bridge side, slave = loader side.
interface dfe_coeff_loader_if #(
  parameter int COEFF_WIDTH = 20
);

  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [2:0]             cfg_sel;
  logic [COEFF_WIDTH-1:0] cfg_data;
  logic                   cfg_last;

  modport master (
    output cfg_valid,
    output cfg_sel,
    output cfg_data,
    output cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_sel,
    input  cfg_data,
    input  cfg_last,
    output cfg_ready
  );

endinterface

// File: rtl/dfe_coeff_loader_bank.sv
// One shadow coefficient bank: an indexed register file with a synchronous
// clear. The contents drive the consumer ports directly.
module coeff_shadow_bank #(
  parameter int DEPTH       = 3,
  parameter int COEFF_WIDTH = 20,
  parameter int IDX_W       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   wr,
  input  logic [IDX_W-1:0]       idx,
  input  logic [COEFF_WIDTH-1:0] data,
  output logic [COEFF_WIDTH-1:0] coeff [DEPTH]
);

  // Clear wins over a write; an index past DEPTH simply matches no entry.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) coeff[i] <= '0;
    end else if (wr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (idx == IDX_W'(i)) coeff[i] <= data;
      end
    end
  end

endmodule

// File: rtl/dfe_coeff_loader.sv
// Coefficient loader for the Phase-1 filter chain.
// Collects a burst of coefficient words into one of seven shadow banks and
// pulses that bank's wr_en only when the burst length matched the bank depth.
// Optional feature: define DFE_COEFF_LOADER_READBACK_EN for the rd_* port set.
module dfe_coeff_loader
  import dfe_coeff_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 20,
  parameter int N_TAP       = 72
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dfe_coeff_loader_if.slave      cfg,
`ifdef DFE_COEFF_LOADER_READBACK_EN
  input  logic [2:0]             rd_sel,
  input  logic [$clog2(N_TAP)-1:0] rd_idx,
  output logic [COEFF_WIDTH-1:0] rd_data,
`endif
  output logic [COEFF_WIDTH-1:0] frac_dec_coeff_data_out [N_TAP],
  output logic                   frac_dec_coeff_wr_en,
  output logic [COEFF_WIDTH-1:0] iir_num_coeff_2_4_out [NUM_COEFF_DEPTH],
  output logic [COEFF_WIDTH-1:0] iir_den_coeff_2_4_out [DEN_COEFF_DEPTH],
  output logic [COEFF_WIDTH-1:0] iir_num_coeff_2_out   [NUM_COEFF_DEPTH],
  output logic [COEFF_WIDTH-1:0] iir_den_coeff_2_out   [DEN_COEFF_DEPTH],
  output logic [COEFF_WIDTH-1:0] iir_num_coeff_1_out   [NUM_COEFF_DEPTH],
  output logic [COEFF_WIDTH-1:0] iir_den_coeff_1_out   [DEN_COEFF_DEPTH],
  output logic                   iir_num_coeff_2_4_wr_en,
  output logic                   iir_den_coeff_2_4_wr_en,
  output logic                   iir_num_coeff_2_wr_en,
  output logic                   iir_den_coeff_2_wr_en,
  output logic                   iir_num_coeff_1_wr_en,
  output logic                   iir_den_coeff_1_wr_en,
  output logic                   busy,
  output logic                   cfg_error
);

  localparam int CNT_W     = $clog2(N_TAP + 1);
  localparam int NUM_BANKS = 7;

  // DATA_WIDTH only rides along for parameter uniformity across the chain.
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("dfe_coeff_loader: DATA_WIDTH must be positive");
  end

  loader_state_e          state, next_state;
  coeff_target_e          sel_q, sel_d, cur_sel;
  logic [CNT_W-1:0]       count, count_d, count_inc, depth;
  logic                   accept, word_err, burst_done, in_burst;
  logic [NUM_BANKS-1:0]   wr_bank, wr_en_d, wr_en_q;
  logic                   err_d, err_q, busy_d, busy_q, ready_d, ready_q;

  // Classify the word on the bus against the bank it belongs to.
  always_comb begin
    accept     = cfg.cfg_valid && ready_q;
    in_burst   = (state == IDLE) || (state == LOAD);
    cur_sel    = (state == IDLE) ? coeff_target_e'(cfg.cfg_sel) : sel_q;
    depth      = CNT_W'(target_depth(cur_sel, N_TAP));
    count_inc  = count + 1'b1;
    word_err   = (coeff_target_e'(cfg.cfg_sel) == TGT_ILLEGAL)
              || ((state == LOAD) && (coeff_target_e'(cfg.cfg_sel) != sel_q))
              || (count >= depth)
              || (cfg.cfg_last && (count_inc < depth));
    burst_done = cfg.cfg_last && (count_inc == depth);
  end

  // State register: FSM state, latched bank and word counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel_q <= TGT_FRAC_DEC;
      count <= '0;
    end else begin
      state <= next_state;
      sel_q <= sel_d;
      count <= count_d;
    end
  end

  // Next-state logic: an error ends the burst in IDLE if it carried last,
  // otherwise DRAIN swallows the remainder of the burst.
  always_comb begin
    next_state = state;
    sel_d      = sel_q;
    count_d    = count;
    case (state)
      IDLE, LOAD: begin
        if (accept) begin
          if (word_err) begin
            next_state = cfg.cfg_last ? IDLE : DRAIN;
            count_d    = '0;
          end else if (burst_done) begin
            next_state = COMMIT;
            sel_d      = cur_sel;
            count_d    = '0;
          end else begin
            next_state = LOAD;
            sel_d      = cur_sel;
            count_d    = count_inc;
          end
        end
      end
      COMMIT:  next_state = IDLE;
      DRAIN:   if (accept && cfg.cfg_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: bank write for good words, and the next values of the
  // registered strobes and status flags.
  always_comb begin
    wr_bank = '0;
    wr_en_d = '0;
    if (in_burst && accept && !word_err) wr_bank[cur_sel] = 1'b1;
    if ((state != COMMIT) && (next_state == COMMIT)) wr_en_d[sel_d] = 1'b1;
    err_d   = in_burst && accept && word_err;
    busy_d  = (next_state != IDLE);
    ready_d = (next_state != COMMIT);
  end

  // Output registers; ready stays low for as long as reset is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      wr_en_q <= wr_en_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign cfg.cfg_ready             = ready_q;
  assign busy                      = busy_q;
  assign cfg_error                 = err_q;
  assign frac_dec_coeff_wr_en      = wr_en_q[0];
  assign iir_num_coeff_2_4_wr_en   = wr_en_q[1];
  assign iir_den_coeff_2_4_wr_en   = wr_en_q[2];
  assign iir_num_coeff_2_wr_en     = wr_en_q[3];
  assign iir_den_coeff_2_wr_en     = wr_en_q[4];
  assign iir_num_coeff_1_wr_en     = wr_en_q[5];
  assign iir_den_coeff_1_wr_en     = wr_en_q[6];

  coeff_shadow_bank #(.DEPTH(N_TAP), .COEFF_WIDTH(COEFF_WIDTH), .IDX_W(CNT_W)) u_bank_frac_dec (
    .clk(clk), .clear(!rst_n), .wr(wr_bank[0]), .idx(count), .data(cfg.cfg_data),
    .coeff(frac_dec_coeff_data_out));
  coeff_shadow_bank #(.DEPTH(NUM_COEFF_DEPTH), .COEFF_WIDTH(COEFF_WIDTH), .IDX_W(CNT_W)) u_bank_num_2_4 (
    .clk(clk), .clear(!rst_n), .wr(wr_bank[1]), .idx(count), .data(cfg.cfg_data),
    .coeff(iir_num_coeff_2_4_out));
  coeff_shadow_bank #(.DEPTH(DEN_COEFF_DEPTH), .COEFF_WIDTH(COEFF_WIDTH), .IDX_W(CNT_W)) u_bank_den_2_4 (
    .clk(clk), .clear(!rst_n), .wr(wr_bank[2]), .idx(count), .data(cfg.cfg_data),
    .coeff(iir_den_coeff_2_4_out));
  coeff_shadow_bank #(.DEPTH(NUM_COEFF_DEPTH), .COEFF_WIDTH(COEFF_WIDTH), .IDX_W(CNT_W)) u_bank_num_2 (
    .clk(clk), .clear(!rst_n), .wr(wr_bank[3]), .idx(count), .data(cfg.cfg_data),
    .coeff(iir_num_coeff_2_out));
  coeff_shadow_bank #(.DEPTH(DEN_COEFF_DEPTH), .COEFF_WIDTH(COEFF_WIDTH), .IDX_W(CNT_W)) u_bank_den_2 (
    .clk(clk), .clear(!rst_n), .wr(wr_bank[4]), .idx(count), .data(cfg.cfg_data),
    .coeff(iir_den_coeff_2_out));
  coeff_shadow_bank #(.DEPTH(NUM_COEFF_DEPTH), .COEFF_WIDTH(COEFF_WIDTH), .IDX_W(CNT_W)) u_bank_num_1 (
    .clk(clk), .clear(!rst_n), .wr(wr_bank[5]), .idx(count), .data(cfg.cfg_data),
    .coeff(iir_num_coeff_1_out));
  coeff_shadow_bank #(.DEPTH(DEN_COEFF_DEPTH), .COEFF_WIDTH(COEFF_WIDTH), .IDX_W(CNT_W)) u_bank_den_1 (
    .clk(clk), .clear(!rst_n), .wr(wr_bank[6]), .idx(count), .data(cfg.cfg_data),
    .coeff(iir_den_coeff_1_out));

`ifdef DFE_COEFF_LOADER_READBACK_EN
  localparam int RD_W = $clog2(N_TAP);

  logic [COEFF_WIDTH-1:0] rd_next;

  // Readback mux; an illegal bank or an index past the bank depth reads 0.
  always_comb begin
    rd_next = '0;
    case (rd_sel)
      3'd0: for (int i = 0; i < N_TAP; i++)
              if (rd_idx == RD_W'(i)) rd_next = frac_dec_coeff_data_out[i];
      3'd1: for (int i = 0; i < NUM_COEFF_DEPTH; i++)
              if (rd_idx == RD_W'(i)) rd_next = iir_num_coeff_2_4_out[i];
      3'd2: for (int i = 0; i < DEN_COEFF_DEPTH; i++)
              if (rd_idx == RD_W'(i)) rd_next = iir_den_coeff_2_4_out[i];
      3'd3: for (int i = 0; i < NUM_COEFF_DEPTH; i++)
              if (rd_idx == RD_W'(i)) rd_next = iir_num_coeff_2_out[i];
      3'd4: for (int i = 0; i < DEN_COEFF_DEPTH; i++)
              if (rd_idx == RD_W'(i)) rd_next = iir_den_coeff_2_out[i];
      3'd5: for (int i = 0; i < NUM_COEFF_DEPTH; i++)
              if (rd_idx == RD_W'(i)) rd_next = iir_num_coeff_1_out[i];
      3'd6: for (int i = 0; i < DEN_COEFF_DEPTH; i++)
              if (rd_idx == RD_W'(i)) rd_next = iir_den_coeff_1_out[i];
      default: rd_next = '0;
    endcase
  end

  // Readback register, one cycle behind rd_sel/rd_idx.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_next;
  end
`endif

endmodule

// File: tb/tb_dfe_coeff_loader.sv
// Directed testbench for dfe_coeff_loader.
// Words are driven on the falling edge and outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
module tb_dfe_coeff_loader;

  localparam int CW    = 20;
  localparam int N_TAP = 72;
  localparam int NUMD  = 3;
  localparam int DEND  = 2;

  logic clk = 1'b0;
  logic rst_n;

  dfe_coeff_loader_if #(.COEFF_WIDTH(CW)) cfg_if ();

  logic [CW-1:0] frac_out   [N_TAP];
  logic [CW-1:0] num_24_out [NUMD];
  logic [CW-1:0] den_24_out [DEND];
  logic [CW-1:0] num_2_out  [NUMD];
  logic [CW-1:0] den_2_out  [DEND];
  logic [CW-1:0] num_1_out  [NUMD];
  logic [CW-1:0] den_1_out  [DEND];
  logic [6:0]    wr_en_vec;
  logic          busy, cfg_error;
`ifdef DFE_COEFF_LOADER_READBACK_EN
  logic [2:0]    rd_sel;
  logic [6:0]    rd_idx;
  logic [CW-1:0] rd_data;
`endif

  int vector_count     = 0;
  int miscompare_count = 0;
  int wr_pulses  [7]   = '{default: 0};
  int pulse_base [7]   = '{default: 0};

  dfe_coeff_loader #(.DATA_WIDTH(16), .COEFF_WIDTH(CW), .N_TAP(N_TAP)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .cfg                     (cfg_if),
`ifdef DFE_COEFF_LOADER_READBACK_EN
    .rd_sel                  (rd_sel),
    .rd_idx                  (rd_idx),
    .rd_data                 (rd_data),
`endif
    .frac_dec_coeff_data_out (frac_out),
    .frac_dec_coeff_wr_en    (wr_en_vec[0]),
    .iir_num_coeff_2_4_out   (num_24_out),
    .iir_den_coeff_2_4_out   (den_24_out),
    .iir_num_coeff_2_out     (num_2_out),
    .iir_den_coeff_2_out     (den_2_out),
    .iir_num_coeff_1_out     (num_1_out),
    .iir_den_coeff_1_out     (den_1_out),
    .iir_num_coeff_2_4_wr_en (wr_en_vec[1]),
    .iir_den_coeff_2_4_wr_en (wr_en_vec[2]),
    .iir_num_coeff_2_wr_en   (wr_en_vec[3]),
    .iir_den_coeff_2_wr_en   (wr_en_vec[4]),
    .iir_num_coeff_1_wr_en   (wr_en_vec[5]),
    .iir_den_coeff_1_wr_en   (wr_en_vec[6]),
    .busy                    (busy),
    .cfg_error               (cfg_error)
  );

  always #5 clk = ~clk;

  // Count every cycle each strobe is high.
  always @(posedge clk) begin
    for (int b = 0; b < 7; b++) if (wr_en_vec[b] === 1'b1) wr_pulses[b]++;
  end

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no end of test, expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vector_count++;
    assert (observed === expected) else begin
      miscompare_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Strobe cycles per bank since the previous call; expect_bank < 0 means none.
  task automatic checkPulses(input string tag, input int expect_bank);
    for (int b = 0; b < 7; b++) begin
      checkOutput($sformatf("%s_wr%0d", tag, b), 32'(wr_pulses[b] - pulse_base[b]),
                  (b == expect_bank) ? 32'd1 : 32'd0);
    end
    pulse_base = wr_pulses;
  endtask

  // Present one word from a falling edge, wait for ready, and return on the
  // falling edge right after the accepting rising edge.
  task automatic applyStimulus(input logic [2:0] sel, input logic [CW-1:0] data,
                               input logic last);
    int waited = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel   = sel;
    cfg_if.cfg_data  = data;
    cfg_if.cfg_last  = last;
    while (cfg_if.cfg_ready !== 1'b1 && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 16) checkOutput("ready_timeout", 32'(cfg_if.cfg_ready), 32'd1);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last  = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_sel   = 3'd0;
    cfg_if.cfg_data  = '0;
    cfg_if.cfg_last  = 1'b0;
`ifdef DFE_COEFF_LOADER_READBACK_EN
    rd_sel = 3'd0;
    rd_idx = 7'd0;
`endif
    $display("[TB] start");

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
    checkOutput("rst_busy",  32'(busy),             32'd0);
    checkOutput("rst_error", 32'(cfg_error),        32'd0);
    checkOutput("rst_wr_en", 32'(wr_en_vec),        32'd0);
    checkOutput("rst_frac0", 32'(frac_out[0]),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    checkOutput("post_rst_busy",  32'(busy),             32'd0);
    checkPulses("rst", -1);

    // Bank 0: 72 words, value k at index k.
    for (int k = 0; k < N_TAP; k++) applyStimulus(3'd0, CW'(k), k == N_TAP - 1);
    checkOutput("b0_wr_en_t1", 32'(wr_en_vec),        32'h01);
    checkOutput("b0_busy_t1",  32'(busy),             32'd1);
    checkOutput("b0_ready_t1", 32'(cfg_if.cfg_ready), 32'd0);
    checkOutput("b0_out71",    32'(frac_out[71]),     32'd71);
    checkOutput("b0_out0",     32'(frac_out[0]),      32'd0);
    checkOutput("b0_out36",    32'(frac_out[36]),     32'd36);
    @(negedge clk);
    checkOutput("b0_wr_en_t2", 32'(wr_en_vec),        32'h00);
    checkOutput("b0_ready_t2", 32'(cfg_if.cfg_ready), 32'd1);
    checkOutput("b0_busy_t2",  32'(busy),             32'd0);
    checkPulses("b0", 0);

    // Bank 2 (den_2_4): -5 then 7.
    applyStimulus(3'd2, 20'hFFFFB, 1'b0);
    applyStimulus(3'd2, 20'd7,     1'b1);
    checkOutput("b2_wr_en_t1", 32'(wr_en_vec),      32'h04);
    checkOutput("b2_out0",     32'(den_24_out[0]),  32'h000F_FFFB);
    checkOutput("b2_out1",     32'(den_24_out[1]),  32'd7);
    checkOutput("b2_num24_0",  32'(num_24_out[0]),  32'd0);
    checkOutput("b2_den2_0",   32'(den_2_out[0]),   32'd0);
    checkOutput("b2_num1_2",   32'(num_1_out[2]),   32'd0);
    @(negedge clk);
    checkPulses("b2", 2);

    // Bank 1: short burst (2 of 3), then a correct 3-word burst.
    applyStimulus(3'd1, 20'd10, 1'b0);
    applyStimulus(3'd1, 20'd20, 1'b1);
    checkOutput("b1_short_err",  32'(cfg_error),     32'd1);
    checkOutput("b1_short_busy", 32'(busy),          32'd0);
    checkOutput("b1_short_wr",   32'(wr_en_vec),     32'h00);
    checkOutput("b1_short_idx1", 32'(num_24_out[1]), 32'd0);
    applyStimulus(3'd1, 20'd1, 1'b0);
    checkOutput("b1_err_clear",  32'(cfg_error),     32'd0);
    applyStimulus(3'd1, 20'd2, 1'b0);
    applyStimulus(3'd1, 20'd3, 1'b1);
    checkOutput("b1_wr_en_t1",   32'(wr_en_vec),     32'h02);
    checkOutput("b1_out0",       32'(num_24_out[0]), 32'd1);
    checkOutput("b1_out2",       32'(num_24_out[2]), 32'd3);
    @(negedge clk);
    checkPulses("b1", 1);

    // Bank 5: fourth word without last overruns, fifth with last drains out.
    applyStimulus(3'd5, 20'd1, 1'b0);
    applyStimulus(3'd5, 20'd2, 1'b0);
    applyStimulus(3'd5, 20'd3, 1'b0);
    checkOutput("b5_no_err_3", 32'(cfg_error),        32'd0);
    applyStimulus(3'd5, 20'd4, 1'b0);
    checkOutput("b5_ovr_err",   32'(cfg_error),        32'd1);
    checkOutput("b5_drain_bsy", 32'(busy),             32'd1);
    checkOutput("b5_drain_rdy", 32'(cfg_if.cfg_ready), 32'd1);
    applyStimulus(3'd5, 20'd5, 1'b1);
    checkOutput("b5_idle_busy", 32'(busy),             32'd0);
    checkOutput("b5_idle_err",  32'(cfg_error),        32'd0);
    @(negedge clk);
    checkPulses("b5", -1);

    // Select change mid-burst, then an illegal select.
    applyStimulus(3'd3, 20'd9, 1'b0);
    applyStimulus(3'd4, 20'd9, 1'b0);
    checkOutput("chg_err",  32'(cfg_error), 32'd1);
    checkOutput("chg_busy", 32'(busy),      32'd1);
    applyStimulus(3'd4, 20'd9, 1'b1);
    checkOutput("chg_idle", 32'(busy),      32'd0);
    applyStimulus(3'd7, 20'd9, 1'b1);
    checkOutput("sel7_err",  32'(cfg_error), 32'd1);
    checkOutput("sel7_busy", 32'(busy),      32'd0);
    @(negedge clk);
    checkPulses("err", -1);

    // Reset in the middle of a bank 0 burst.
    for (int k = 0; k < 30; k++) applyStimulus(3'd0, CW'(100 + k), 1'b0);
    checkOutput("mid_busy",   32'(busy),         32'd1);
    checkOutput("mid_frac29", 32'(frac_out[29]), 32'd129);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mrst_frac29", 32'(frac_out[29]),     32'd0);
    checkOutput("mrst_frac71", 32'(frac_out[71]),     32'd0);
    checkOutput("mrst_den24",  32'(den_24_out[0]),    32'd0);
    checkOutput("mrst_num24",  32'(num_24_out[2]),    32'd0);
    checkOutput("mrst_busy",   32'(busy),             32'd0);
    checkOutput("mrst_ready",  32'(cfg_if.cfg_ready), 32'd0);
    checkOutput("mrst_error",  32'(cfg_error),        32'd0);
    checkOutput("mrst_wr_en",  32'(wr_en_vec),        32'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkPulses("mrst", -1);

`ifdef DFE_COEFF_LOADER_READBACK_EN
    // Readback of a committed bank 0 entry, then an illegal select.
    for (int k = 0; k < N_TAP; k++) applyStimulus(3'd0, CW'(k), k == N_TAP - 1);
    @(negedge clk);
    rd_sel = 3'd0;
    rd_idx = 7'd71;
    @(negedge clk);
    checkOutput("rb_b0_71", 32'(rd_data), 32'd71);
    rd_sel = 3'd7;
    @(negedge clk);
    checkOutput("rb_sel7", 32'(rd_data), 32'd0);
    checkPulses("rb", 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
